// File: rtl/store_buffer.sv
// Posted-write buffer: single-cycle store acceptance, in-order drain to data memory
// over req/ack, and youngest-match load forwarding from the pending entries.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push, pop;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign st_ready = (count_q != CW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign pop      = (state_q == DRAIN) && mem_ack;
  assign empty    = (count_q == '0) && (state_q == IDLE);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0 || push) state_d = DRAIN;
      end
      DRAIN: begin
        mem_req   = 1'b1;
        mem_addr  = addr_q[rd_ptr_q];
        mem_wdata = data_q[rd_ptr_q];
        if (pop && count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_q[gi] && (addr_q[gi] == ld_addr);
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (match[idx]) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer: drain order, full handling,
// youngest-match forwarding, back-to-back drain and reset abandonment.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic        empty;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        pend[$];
  ent_t        expw[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .ld_data(ld_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Memory side: record every accepted write.
  always @(posedge clk) begin
    if (reset && mem_req && mem_ack) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ga, gd;
    ga = 32'hDEAD_BEEF;
    gd = 32'hDEAD_BEEF;
    if (log_a.size() > 0) begin
      ga = log_a.pop_front();
      gd = log_d.pop_front();
    end
    chk({tag, "_addr"}, ga, a);
    chk({tag, "_data"}, gd, d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        m_hit, push, pop;
    logic [31:0] m_data;
    ent_t        e;

    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = '0; mem_ack = 1'b0;
    tick; tick;
    reset = 1'b1;
    #1;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);

    // Three stores with ack held low, then drain in order.
    st_valid = 1; st_addr = 32'h10; st_data = 32'hA; tick;
    chk("t1_count1", count, 1);
    chk("t1_req1", mem_req, 1);
    chk("t1_addr1", mem_addr, 32'h10);
    st_addr = 32'h14; st_data = 32'hB; tick;
    st_addr = 32'h18; st_data = 32'hC; tick;
    st_valid = 0;
    chk("t1_count3", count, 3);
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_wdata", mem_wdata, 32'hA);
    tick;
    chk("t1_addr_hold", mem_addr, 32'h10);
    mem_ack = 1; tick; tick; tick; mem_ack = 0;
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);
    expect_write("t1_w0", 32'h10, 32'hA);
    expect_write("t1_w1", 32'h14, 32'hB);
    expect_write("t1_w2", 32'h18, 32'hC);

    // Fill, drop while full, ack and push in the same cycle.
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 32'h40 + 32'(4*i); st_data = 32'h100 + 32'(i); tick;
    end
    chk("t2_count4", count, 4);
    chk("t2_ready0", st_ready, 0);
    st_addr = 32'h50; st_data = 32'h104; #1;
    chk("t2_ready_full", st_ready, 0);
    tick;
    chk("t2_drop_count", count, 4);
    mem_ack = 1; ld_addr = 32'h40; #1;
    chk("t2_ready_ack", st_ready, 0);
    chk("t2_head_hit", ld_hit, 1);
    chk("t2_head_data", ld_data, 32'h100);
    tick;
    st_valid = 0; mem_ack = 0;
    chk("t2_count3", count, 3);
    chk("t2_next_head", mem_addr, 32'h44);
    ld_addr = 32'h44; #1;
    chk("t2_fwd_hit", ld_hit, 1);
    chk("t2_fwd_data", ld_data, 32'h101);
    ld_addr = 32'h40; #1;
    chk("t2_popped_hit", ld_hit, 0);
    chk("t2_popped_data", ld_data, 0);
    ld_addr = 32'h50; #1;
    chk("t2_dropped_hit", ld_hit, 0);
    mem_ack = 1; tick; tick; tick; mem_ack = 0;
    chk("t2_empty", empty, 1);
    expect_write("t2_w0", 32'h40, 32'h100);
    expect_write("t2_w1", 32'h44, 32'h101);
    expect_write("t2_w2", 32'h48, 32'h102);
    expect_write("t2_w3", 32'h4C, 32'h103);
    chk("t2_no_extra", log_a.size(), 0);

    // Same address twice; entries straddle the pointer wrap.
    st_valid = 1; st_addr = 32'h20; st_data = 32'h1; ld_addr = 32'h20; #1;
    chk("t3_push_nofwd", ld_hit, 0);
    tick;
    st_data = 32'h2; tick;
    st_valid = 0; #1;
    chk("t3_hit", ld_hit, 1);
    chk("t3_youngest", ld_data, 32'h2);
    mem_ack = 1; tick;
    chk("t3_count1", count, 1);
    chk("t3_hit_after_pop", ld_hit, 1);
    chk("t3_data_after_pop", ld_data, 32'h2);
    tick; mem_ack = 0;
    chk("t3_count0", count, 0);
    chk("t3_miss", ld_hit, 0);
    chk("t3_miss_data", ld_data, 0);
    expect_write("t3_w0", 32'h20, 32'h1);
    expect_write("t3_w1", 32'h20, 32'h2);

    // Continuous ack, one store per cycle.
    mem_ack = 1;
    for (int i = 0; i < 8; i++) begin
      st_valid = 1; st_addr = 32'h80 + 32'(4*i); st_data = 32'h200 + 32'(i); tick;
      chk("t4_count", count, 1);
      chk("t4_req", mem_req, 1);
      chk("t4_head", mem_addr, 32'h80 + 32'(4*i));
    end
    st_valid = 0; tick; mem_ack = 0;
    chk("t4_count0", count, 0);
    chk("t4_empty", empty, 1);
    chk("t4_req0", mem_req, 0);
    for (int i = 0; i < 8; i++)
      expect_write("t4_w", 32'h80 + 32'(4*i), 32'h200 + 32'(i));

    // Reset with two entries pending and a request outstanding.
    st_valid = 1; st_addr = 32'h90; st_data = 32'h300; tick;
    st_addr = 32'h94; st_data = 32'h301; tick;
    st_valid = 0;
    chk("t5_count2", count, 2);
    chk("t5_req1", mem_req, 1);
    reset = 0; mem_ack = 1; tick;
    chk("t5_req0", mem_req, 0);
    chk("t5_count0", count, 0);
    chk("t5_empty", empty, 1);
    reset = 1; tick; tick; tick;
    chk("t5_req_still0", mem_req, 0);
    chk("t5_no_writes", log_a.size(), 0);
    mem_ack = 0;

    // Random mix against a queue model.
    for (int cyc = 0; cyc < 300; cyc++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = 32'hA0 + 32'(4*$urandom_range(0, 2));
      st_data  = $urandom;
      mem_ack  = ($urandom_range(0, 2) != 0);
      ld_addr  = 32'hA0 + 32'(4*$urandom_range(0, 3));
      #1;
      m_hit = 0; m_data = '0;
      foreach (pend[i]) if (pend[i].a == ld_addr) begin m_hit = 1; m_data = pend[i].d; end
      chk("rnd_hit", ld_hit, m_hit);
      chk("rnd_ldata", ld_data, m_data);
      chk("rnd_ready", st_ready, pend.size() != 4);
      chk("rnd_count", count, pend.size());
      chk("rnd_req", mem_req, pend.size() != 0);
      if (pend.size() != 0) chk("rnd_maddr", mem_addr, pend[0].a);
      push = st_valid && (pend.size() < 4);
      pop  = mem_ack && (pend.size() != 0);
      if (pop) expw.push_back(pend.pop_front());
      if (push) begin e.a = st_addr; e.d = st_data; pend.push_back(e); end
      tick;
    end
    st_valid = 0; mem_ack = 1;
    for (int i = 0; i < 10 && pend.size() != 0; i++) begin
      expw.push_back(pend.pop_front());
      tick;
    end
    mem_ack = 0;
    chk("rnd_empty", empty, 1);
    chk("rnd_nwrites", log_a.size(), expw.size());
    while (expw.size() != 0) begin
      e = expw.pop_front();
      expect_write("rnd_w", e.a, e.d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
